irq_sched: RTL and testbench

- Interrupt scheduler in front of the WB-stage trap controller.
- Masks and prioritises the raw interrupt lines, latches one winner, and presents it to the trap controller only when a clean instruction sits in WB.
- After a trap it enforces a hold-off window so the handler's first instruction retires before any re-evaluation.
- Sits between the platform interrupt sources and the software/timer/external/debug interrupt inputs of the trap controller.

---
 rtl/irq_sched.sv | 168 ++++++++++++++++
 tb/tb_irq_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/irq_sched.sv
// Interrupt scheduler: masks, prioritises and latches one interrupt, presents it to the trap controller
// on a clean WB instruction, then holds off re-evaluation. Define IRQ_SYNC_EN to synchronise raw lines.
module irq_sched #(
  parameter int unsigned HOLDOFF_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       software_interrupt,
  input  logic       timer_interrupt,
  input  logic       external_interrupt,
  input  logic       debug_interrupt,
  input  logic       mstatus_mie,
  input  logic       mie_msie,
  input  logic       mie_mtie,
  input  logic       mie_meie,
  input  logic       wb_valid,
  input  logic       wb_exc,
  input  logic       take_trap,
  output logic       irq_software,
  output logic       irq_timer,
  output logic       irq_external,
  output logic       irq_debug,
  output logic [3:0] irq_code,
  output logic [2:0] mip,
  output logic       irq_busy
);

  typedef enum logic [1:0] {IDLE, PENDING, HOLDOFF} state_e;

  localparam logic [3:0] CODE_NONE = 4'd0;
  localparam logic [3:0] CODE_SW   = 4'd3;
  localparam logic [3:0] CODE_TMR  = 4'd7;
  localparam logic [3:0] CODE_EXT  = 4'd11;
  localparam logic [3:0] CODE_DBG  = 4'd15;

  // line[3:0] = {debug, external, timer, software}
  logic [3:0] raw, line;
  assign raw = {debug_interrupt, external_interrupt, timer_interrupt, software_interrupt};

`ifdef IRQ_SYNC_EN
  logic [3:0] sync1_d, sync1_q, sync2_d, sync2_q;
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
  assign line = sync2_q;
`else
  assign line = raw;
`endif

  logic elig_dbg, elig_ext, elig_sw, elig_tmr;
  assign elig_dbg = line[3];
  assign elig_ext = line[2] & mie_meie & mstatus_mie;
  assign elig_sw  = line[0] & mie_msie & mstatus_mie;
  assign elig_tmr = line[1] & mie_mtie & mstatus_mie;

  // Rank 0 means nothing eligible; larger rank wins.
  logic [3:0] win_code;
  logic [2:0] win_rank;
  always_comb begin
    win_code = CODE_NONE;
    win_rank = 3'd0;
    if (elig_dbg) begin
      win_code = CODE_DBG; win_rank = 3'd4;
    end else if (elig_ext) begin
      win_code = CODE_EXT; win_rank = 3'd3;
    end else if (elig_sw) begin
      win_code = CODE_SW;  win_rank = 3'd2;
    end else if (elig_tmr) begin
      win_code = CODE_TMR; win_rank = 3'd1;
    end
  end

  state_e     state_d, state_q;
  logic [3:0] code_d, code_q;
  logic [3:0] cnt_d, cnt_q;
  logic [2:0] mip_d, mip_q;

  logic       lat_elig;
  logic [2:0] lat_rank;
  always_comb begin
    lat_elig = 1'b0;
    lat_rank = 3'd0;
    case (code_q)
      CODE_DBG: begin lat_elig = elig_dbg; lat_rank = 3'd4; end
      CODE_EXT: begin lat_elig = elig_ext; lat_rank = 3'd3; end
      CODE_SW:  begin lat_elig = elig_sw;  lat_rank = 3'd2; end
      CODE_TMR: begin lat_elig = elig_tmr; lat_rank = 3'd1; end
      default:  begin lat_elig = 1'b0;     lat_rank = 3'd0; end
    endcase
  end

  // Gated by rst so nothing reaches the trap controller while reset is held.
  logic fire;
  assign fire = rst & (state_q == PENDING) & wb_valid & ~wb_exc & lat_elig;

  assign irq_software = fire & (code_q == CODE_SW);
  assign irq_timer    = fire & (code_q == CODE_TMR);
  assign irq_external = fire & (code_q == CODE_EXT);
  assign irq_debug    = fire & (code_q == CODE_DBG);
  assign irq_code     = code_q;
  assign mip          = mip_q;
  assign irq_busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    mip_d   = line[2:0];
    case (state_q)
      IDLE: begin
        if (win_rank != 3'd0) begin
          code_d  = win_code;
          state_d = PENDING;
        end
      end
      PENDING: begin
        // A dropped request returns to IDLE; the next winner is picked up there.
        if (!lat_elig) begin
          state_d = IDLE;
          code_d  = CODE_NONE;
        end else if (fire && take_trap) begin
          state_d = HOLDOFF;
          cnt_d   = 4'(HOLDOFF_CYCLES - 1);
        end else if (win_rank > lat_rank) begin
          code_d = win_code;
        end
      end
      HOLDOFF: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          code_d  = CODE_NONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = CODE_NONE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      code_q  <= CODE_NONE;
      cnt_q   <= 4'd0;
      mip_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      mip_q   <= mip_d;
    end
  end

endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched; timing adapts to the synchroniser latency when IRQ_SYNC_EN is defined.
module tb_irq_sched;

`ifdef IRQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       software_interrupt, timer_interrupt, external_interrupt, debug_interrupt;
  logic       mstatus_mie, mie_msie, mie_mtie, mie_meie;
  logic       wb_valid, wb_exc, take_trap;
  logic       irq_software, irq_timer, irq_external, irq_debug;
  logic [3:0] irq_code;
  logic [2:0] mip;
  logic       irq_busy;
  logic       echo, tt_force;
  logic [3:0] irqs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign irqs      = {irq_debug, irq_external, irq_timer, irq_software};
  assign take_trap = echo ? (|irqs) : tt_force;

  irq_sched #(.HOLDOFF_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .software_interrupt(software_interrupt), .timer_interrupt(timer_interrupt),
    .external_interrupt(external_interrupt), .debug_interrupt(debug_interrupt),
    .mstatus_mie(mstatus_mie), .mie_msie(mie_msie), .mie_mtie(mie_mtie), .mie_meie(mie_meie),
    .wb_valid(wb_valid), .wb_exc(wb_exc), .take_trap(take_trap),
    .irq_software(irq_software), .irq_timer(irq_timer),
    .irq_external(irq_external), .irq_debug(irq_debug),
    .irq_code(irq_code), .mip(mip), .irq_busy(irq_busy)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    software_interrupt = 0; timer_interrupt = 1; external_interrupt = 0; debug_interrupt = 0;
    mstatus_mie = 1; mie_msie = 0; mie_mtie = 1; mie_meie = 0;
    wb_valid = 1; wb_exc = 0; echo = 0; tt_force = 0;
    step; step;
    chk("rst_code", 8'(irq_code), 8'd0);
    chk("rst_busy", 8'(irq_busy), 8'd0);
    chk("rst_mip",  8'(mip), 8'd0);
    chk("rst_irq",  8'(irqs), 8'd0);
    timer_interrupt = 0; rst = 1'b1;
    step;
    chk("post_rst_irq", 8'(irqs), 8'd0);

    // Timer only, trap taken as soon as the request is presented
    timer_interrupt = 1; echo = 1; #1;
    chk("t_idle", 8'(irq_busy), 8'd0);
    for (int i = 0; i < SL; i++) begin
      step;
      chk("t_sync", 8'(irq_busy), 8'd0);
    end
    step;
    chk("t_pend",  8'(irq_busy), 8'd1);
    chk("t_code",  8'(irq_code), 8'd7);
    chk("t_irq",   8'(irqs), 8'b0010);
    chk("t_mip",   8'(mip), 8'b010);
    step;
    chk("t_hold1_irq",  8'(irqs), 8'd0);
    chk("t_hold1_busy", 8'(irq_busy), 8'd1);
    chk("t_hold1_code", 8'(irq_code), 8'd7);
    step;
    chk("t_hold2_busy", 8'(irq_busy), 8'd1);
    chk("t_hold2_code", 8'(irq_code), 8'd7);
    step;
    chk("t_idle2_busy", 8'(irq_busy), 8'd0);
    chk("t_idle2_code", 8'(irq_code), 8'd0);
    step;
    chk("t_repend_code", 8'(irq_code), 8'd7);
    chk("t_repend_irq",  8'(irqs), 8'b0010);
    echo = 0; timer_interrupt = 0;
    repeat (SL + 1) step;
    chk("t_drop_busy", 8'(irq_busy), 8'd0);
    chk("t_drop_code", 8'(irq_code), 8'd0);

    // Priority
    software_interrupt = 1; timer_interrupt = 1; external_interrupt = 1;
    mie_msie = 1; mie_mtie = 1; mie_meie = 1;
    repeat (SL + 1) step;
    chk("p_code", 8'(irq_code), 8'd11);
    chk("p_irq",  8'(irqs), 8'b0100);
    chk("p_mip",  8'(mip), 8'b111);
    external_interrupt = 0;
    repeat (SL + 1) step;
    chk("p_drop_code", 8'(irq_code), 8'd0);
    chk("p_drop_busy", 8'(irq_busy), 8'd0);
    step;
    chk("p_sw_code", 8'(irq_code), 8'd3);
    chk("p_sw_irq",  8'(irqs), 8'b0001);

    // Masking; debug ignores the global enable
    mstatus_mie = 0; external_interrupt = 1;
    step;
    chk("m_idle", 8'(irq_busy), 8'd0);
    repeat (SL + 1) step;
    chk("m_busy", 8'(irq_busy), 8'd0);
    chk("m_irq",  8'(irqs), 8'd0);
    chk("m_mip",  8'(mip), 8'b111);
    debug_interrupt = 1;
    repeat (SL + 1) step;
    chk("m_dbg_code", 8'(irq_code), 8'd15);
    chk("m_dbg_irq",  8'(irqs), 8'b1000);

    // Exception collision
    debug_interrupt = 0;
    repeat (SL + 1) step;
    chk("x_idle", 8'(irq_busy), 8'd0);
    mstatus_mie = 1;
    step;
    chk("x_code", 8'(irq_code), 8'd11);
    wb_exc = 1; tt_force = 1; #1;
    chk("x_irq", 8'(irqs), 8'd0);
    step;
    chk("x_busy",  8'(irq_busy), 8'd1);
    chk("x_code2", 8'(irq_code), 8'd11);
    mstatus_mie = 0; wb_exc = 0; tt_force = 0;
    step;
    chk("x_drop_busy", 8'(irq_busy), 8'd0);
    chk("x_drop_code", 8'(irq_code), 8'd0);

    // WB bubble
    mstatus_mie = 1; wb_valid = 0;
    step;
    chk("b_code", 8'(irq_code), 8'd11);
    for (int i = 0; i < 5; i++) begin
      chk("b_bubble_irq", 8'(irqs), 8'd0);
      step;
    end
    wb_valid = 1; #1;
    chk("b_fire", 8'(irqs), 8'b0100);
    echo = 1;
    step;
    chk("b_hold_busy", 8'(irq_busy), 8'd1);
    chk("b_hold_irq",  8'(irqs), 8'd0);
    chk("b_hold_code", 8'(irq_code), 8'd11);

    // Reset mid-HOLDOFF
    rst = 0;
    step;
    chk("r_irq",  8'(irqs), 8'd0);
    chk("r_busy", 8'(irq_busy), 8'd0);
    chk("r_code", 8'(irq_code), 8'd0);
    chk("r_mip",  8'(mip), 8'd0);
    rst = 1; echo = 0;
    repeat (SL + 1) step;
    chk("r_repend_code", 8'(irq_code), 8'd11);
    chk("r_repend_busy", 8'(irq_busy), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
